fp_mul_pipe: RTL and testbench
==============================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width in bits.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width in bits; defaults give IEEE-754 single, and 5/10 gives half.
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports Sx, Sy, input, 1 each, operand signs.
REQ-006 SHALL have ports Ex, Ey, input, EXP_W each, biased operand exponents.
REQ-007 SHALL have ports Mx, My, input, MAN_W each, operand fractions.
REQ-008 SHALL have port R_mode, input, 2, rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-009 SHALL have port in_valid, input, 1, operands and R_mode valid this cycle.
REQ-010 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-011 SHALL have ports Sz, Ez, Mz, output, 1/EXP_W/MAN_W, result.
REQ-012 SHALL have port out_valid, output, 1, result and flags valid.
REQ-013 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-014 SHALL have ports invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex, output, 1 each, exception flags aligned with the result.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify and mantissa product; S2 normalise and exponent adjust; S3 round, pack and flags.
REQ-016 SHALL use advance = ~out_valid | out_ready, with in_ready = advance; an operation is accepted when in_valid & in_ready.
REQ-017 SHALL present an accepted operation on out_valid exactly 3 cycles after acceptance while advance stays high.
REQ-018 SHALL freeze all stages, holding outputs stable, while out_valid=1 and out_ready=0; no operation is lost, duplicated or reordered.
REQ-019 SHALL set Sz = Sx ^ Sy, except for NaN results.
REQ-020 SHALL form the product as a (2*MAN_W+2)-bit product of the hidden-bit mantissas, with exponent Ex+Ey-bias carried at EXP_W+2 bits signed.
REQ-021 SHALL compute rounding from guard, round and sticky bits; mantissa carry-out on rounding SHALL increment the exponent.
REQ-022 SHALL give NaN on any input or inf*0 as canonical NaN: Sz=0, Ez all ones, Mz all ones, invalid_flagex=1, other flags 0.
REQ-023 SHALL give inf*finite-nonzero as signed inf with no flags.
REQ-024 SHALL handle overflow as follows: RNE gives inf; RTZ gives max finite; +inf mode gives +inf or -max; -inf mode gives -inf or +max; overflow_flagex=1 and inexact_flagex=1 in all cases.
REQ-025 SHALL set underflow_flagex=1 whenever the rounded result is nonzero-tiny (below min normal), regardless of exactness.
REQ-026 SHALL set zero_flagex=1 whenever Ez=0 and Mz=0.
REQ-027 SHALL set inexact_flagex=1 whenever any discarded bit is nonzero.
REQ-028 SHALL hold all flags at 0 when out_valid=0.

Reset
REQ-029 SHALL force all outputs to 0 while RST=1: out_valid, flags, Sz, Ez and Mz are 0, and in_ready is 1.
REQ-030 SHALL discard all in-flight operations when RST asserts mid-operation; after release, the first result appears 3 cycles after the next accept.

Configuration
REQ-031 SHALL, with macro FP_MUL_SUBNORM_EN defined, normalise subnormal inputs by leading-zero count and produce subnormal results by right-shift with rounding.
REQ-032 SHALL, without FP_MUL_SUBNORM_EN, treat subnormal inputs as signed zero and flush tiny results to signed zero with underflow_flagex=1, zero_flagex=1, and inexact_flagex=1 if the unflushed value was nonzero.
REQ-033 SHALL keep latency and handshake identical in both configurations.

Verification (defaults, RNE unless stated)
REQ-034 SHALL check: 0x40400000 * 0x40000000 -> 0x40C00000, all flags 0, out_valid exactly 3 cycles after accept.
REQ-035 SHALL check: 0x7F800000 * 0x00000000 -> 0x7FFFFFFF with invalid_flagex=1; 0x7FC00000 * 0x3F800000 -> same result.
REQ-036 SHALL check: 0x7F7FFFFF * 0x40000000 -> 0x7F800000 with overflow=1 and inexact=1; with R_mode=01 -> 0x7F7FFFFF with the same flags.
REQ-037 SHALL check: 0x00800000 * 0x3F000000 -> with FP_MUL_SUBNORM_EN, 0x00400000, underflow=1, inexact=0; without it, 0x00000000, underflow=1, zero=1, inexact=1.
REQ-038 SHALL check backpressure: 6 back-to-back ops with out_ready=0 for 5 cycles -> in_ready low once 3 stages plus output are full, results held stable, all 6 emerge in order.
REQ-039 SHALL check reset mid-operation: RST pulsed with 2 ops in flight -> out_valid=0 immediately, no stale result afterward.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 style floating-point multiplier with valid/ready handshake.
// Define FP_MUL_SUBNORM_EN for subnormal inputs/results; otherwise subnormals flush to signed zero.
module fp_mul_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Sx,
   input  logic             Sy,
   input  logic [EXP_W-1:0] Ex,
   input  logic [EXP_W-1:0] Ey,
   input  logic [MAN_W-1:0] Mx,
   input  logic [MAN_W-1:0] My,
   input  logic [1:0]       R_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             Sz,
   output logic [EXP_W-1:0] Ez,
   output logic [MAN_W-1:0] Mz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             invalid_flagex,
   output logic             overflow_flagex,
   output logic             underflow_flagex,
   output logic             inexact_flagex,
   output logic             zero_flagex
);

   localparam int unsigned XW   = EXP_W + 2;
   localparam int unsigned PW   = 2 * MAN_W + 2;
   localparam int unsigned SW   = EXP_W + MAN_W;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned EMAX = (1 << EXP_W) - 1;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

`ifdef FP_MUL_SUBNORM_EN
   localparam int unsigned LZW = $clog2(MAN_W + 2);
   localparam int unsigned SHW = $clog2(PW + 1);

   function automatic logic [LZW-1:0] lzc(input logic [MAN_W:0] v);
      lzc = LZW'(MAN_W + 1);
      for (int i = 0; i <= int'(MAN_W); i++)
         if (v[i]) lzc = LZW'(int'(MAN_W) - i);
   endfunction
`endif

   // ---------------- S1: unpack, classify, mantissa product ----------------
   logic x_ez, y_ez, x_eo, y_eo, x_mz, y_mz;
   logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic c_nan, c_inf, c_zero;
   logic [MAN_W:0] sig_x, sig_y;
   logic [XW-1:0]  ex_e, ey_e;

   assign x_ez  = (Ex == '0);
   assign y_ez  = (Ey == '0);
   assign x_eo  = &Ex;
   assign y_eo  = &Ey;
   assign x_mz  = (Mx == '0);
   assign y_mz  = (My == '0);
   assign x_nan = x_eo & ~x_mz;
   assign y_nan = y_eo & ~y_mz;
   assign x_inf = x_eo & x_mz;
   assign y_inf = y_eo & y_mz;
`ifdef FP_MUL_SUBNORM_EN
   assign x_zero = x_ez & x_mz;
   assign y_zero = y_ez & y_mz;
`else
   assign x_zero = x_ez;
   assign y_zero = y_ez;
`endif
   assign c_nan  = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
   assign c_inf  = (x_inf | y_inf) & ~c_nan;
   assign c_zero = (x_zero | y_zero) & ~c_nan;

   // Hidden-bit significands; subnormals are normalised with a compensated exponent
   always_comb begin
      sig_x = {~x_ez, Mx};
      sig_y = {~y_ez, My};
      ex_e  = XW'(Ex);
      ey_e  = XW'(Ey);
`ifdef FP_MUL_SUBNORM_EN
      if (x_ez) begin
         ex_e  = XW'(1) - XW'(lzc(sig_x));
         sig_x = sig_x << lzc(sig_x);
      end
      if (y_ez) begin
         ey_e  = XW'(1) - XW'(lzc(sig_y));
         sig_y = sig_y << lzc(sig_y);
      end
`endif
   end

   logic            s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
   logic [1:0]      s1_rm;
   logic [XW-1:0]   s1_exp;
   logic [PW-1:0]   s1_prod;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_rm    <= '0;
         s1_exp   <= '0;
         s1_prod  <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_sign  <= Sx ^ Sy;
         s1_nan   <= c_nan;
         s1_inf   <= c_inf;
         s1_zero  <= c_zero;
         s1_rm    <= R_mode;
         s1_exp   <= ex_e + ey_e - XW'(BIAS);
         s1_prod  <= PW'(sig_x) * PW'(sig_y);
      end
   end

   // ---------------- S2: normalise, exponent adjust ----------------
   logic [PW-2:0] nf;
   logic [XW-1:0] e2_c;
   logic          lost;

   always_comb begin
      if (s1_prod[PW-1]) begin
         nf   = s1_prod[PW-2:0];
         e2_c = s1_exp + XW'(1);
      end else begin
         nf   = {s1_prod[PW-3:0], 1'b0};
         e2_c = s1_exp;
      end
      lost = 1'b0;
`ifdef FP_MUL_SUBNORM_EN
      // Tiny results are denormalised here so rounding sees the final bit positions
      if (e2_c[XW-1] || (e2_c == '0)) begin
         logic [XW-1:0]  sh_full;
         logic [SHW-1:0] sh;
         sh_full = XW'(1) - e2_c;
         sh      = (sh_full > XW'(PW)) ? SHW'(PW) : SHW'(sh_full);
         lost    = |({1'b1, nf} & ~({PW{1'b1}} << sh));
         nf      = (PW-1)'({1'b1, nf} >> sh);
         e2_c    = '0;
      end
`endif
   end

   logic            s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
   logic [1:0]      s2_rm;
   logic [XW-1:0]   s2_exp;
   logic [MAN_W-1:0] s2_frac;
   logic            s2_g, s2_r, s2_st;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_rm    <= '0;
         s2_exp   <= '0;
         s2_frac  <= '0;
         s2_g     <= 1'b0;
         s2_r     <= 1'b0;
         s2_st    <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_nan   <= s1_nan;
         s2_inf   <= s1_inf;
         s2_zero  <= s1_zero;
         s2_rm    <= s1_rm;
         s2_exp   <= e2_c;
         s2_frac  <= nf[PW-2 -: MAN_W];
         s2_g     <= nf[MAN_W];
         s2_r     <= nf[MAN_W-1];
         s2_st    <= (|nf[MAN_W-2:0]) | lost;
      end
   end

   // ---------------- S3: round, pack, flags ----------------
   logic             inexact_c, inc, ovf_pre, ovf, tiny, inf_sel;
   logic [EXP_W-1:0] ef;
   logic [SW-1:0]    sum;
   logic             sz_n, inv_n, ovf_n, unf_n, inx_n, zf_n;
   logic [EXP_W-1:0] ez_n;
   logic [MAN_W-1:0] mz_n;

   assign inexact_c = s2_g | s2_r | s2_st;

   always_comb begin
      case (s2_rm)
         RM_RNE:  inc = s2_g & (s2_r | s2_st | s2_frac[0]);
         RM_RUP:  inc = ~s2_sign & inexact_c;
         RM_RDN:  inc = s2_sign & inexact_c;
         default: inc = 1'b0;
      endcase
   end

   // Concatenated add lets a mantissa carry ripple straight into the exponent
   assign ef      = s2_exp[XW-1] ? '0 : s2_exp[EXP_W-1:0];
   assign sum     = {ef, s2_frac} + SW'(inc);
   assign ovf_pre = ~s2_exp[XW-1] & (s2_exp[XW-2:0] >= (XW-1)'(EMAX));
   assign ovf     = ovf_pre | (&sum[SW-1 -: EXP_W]);
   assign tiny    = s2_exp[XW-1] | (sum[SW-1 -: EXP_W] == '0);
   assign inf_sel = (s2_rm == RM_RNE) | ((s2_rm == RM_RUP) & ~s2_sign) |
                    ((s2_rm == RM_RDN) & s2_sign);

   always_comb begin
      sz_n  = 1'b0;
      ez_n  = '0;
      mz_n  = '0;
      inv_n = 1'b0;
      ovf_n = 1'b0;
      unf_n = 1'b0;
      inx_n = 1'b0;
      if (s2_valid) begin
         if (s2_nan) begin
            ez_n  = '1;
            mz_n  = '1;
            inv_n = 1'b1;
         end else if (s2_inf) begin
            sz_n = s2_sign;
            ez_n = '1;
         end else if (s2_zero) begin
            sz_n = s2_sign;
         end else if (ovf) begin
            sz_n  = s2_sign;
            ez_n  = inf_sel ? EXP_W'(EMAX) : EXP_W'(EMAX - 1);
            mz_n  = inf_sel ? '0 : '1;
            ovf_n = 1'b1;
            inx_n = 1'b1;
         end else if (tiny) begin
            sz_n  = s2_sign;
            unf_n = 1'b1;
`ifdef FP_MUL_SUBNORM_EN
            {ez_n, mz_n} = sum;
            inx_n = inexact_c;
`else
            inx_n = 1'b1;
`endif
         end else begin
            sz_n  = s2_sign;
            {ez_n, mz_n} = sum;
            inx_n = inexact_c;
         end
      end
      zf_n = s2_valid & (ez_n == '0) & (mz_n == '0);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid        <= 1'b0;
         Sz               <= 1'b0;
         Ez               <= '0;
         Mz               <= '0;
         invalid_flagex   <= 1'b0;
         overflow_flagex  <= 1'b0;
         underflow_flagex <= 1'b0;
         inexact_flagex   <= 1'b0;
         zero_flagex      <= 1'b0;
      end else if (advance) begin
         out_valid        <= s2_valid;
         Sz               <= sz_n;
         Ez               <= ez_n;
         Mz               <= mz_n;
         invalid_flagex   <= inv_n;
         overflow_flagex  <= ovf_n;
         underflow_flagex <= unf_n;
         inexact_flagex   <= inx_n;
         zero_flagex      <= zf_n;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed scoreboard bench for fp_mul_pipe (single precision); results as {inv,ovf,unf,inx,zero,Sz,Ez,Mz}.
module tb_fp_mul_pipe;

   typedef logic [36:0] res_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Sx, Sy;
   logic [7:0]  Ex, Ey;
   logic [22:0] Mx, My;
   logic [1:0]  R_mode;
   logic        in_valid, in_ready;
   logic        Sz;
   logic [7:0]  Ez;
   logic [22:0] Mz;
   logic        out_valid, out_ready;
   logic        invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic was_stall = 1'b0;
   res_t held;
   res_t got;

   assign got = {invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex,
                 zero_flagex, Sz, Ez, Mz};

   fp_mul_pipe dut (
      .CLK(CLK), .RST(RST),
      .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
      .R_mode(R_mode), .in_valid(in_valid), .in_ready(in_ready),
      .Sz(Sz), .Ez(Ez), .Mz(Mz),
      .out_valid(out_valid), .out_ready(out_ready),
      .invalid_flagex(invalid_flagex), .overflow_flagex(overflow_flagex),
      .underflow_flagex(underflow_flagex), .inexact_flagex(inexact_flagex),
      .zero_flagex(zero_flagex)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input res_t obs, input res_t expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
      Sx = a[31]; Ex = a[30:23]; Mx = a[22:0];
      Sy = b[31]; Ey = b[30:23]; My = b[22:0];
      R_mode   = rm;
      in_valid = 1'b1;
   endtask

   // Present one operation and hold it until accepted (bounded)
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input bit push, input res_t expv);
      int n = 0;
      drive(a, b, rm);
      @(negedge CLK);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge CLK);
      end
      chk("accept", 37'(in_ready), 37'(1));
      if (push) sb.push_back(expv);
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   // Single operation into an idle pipe with cycle-exact latency checks
   task automatic lat_op(input logic [31:0] a, input logic [31:0] b, input res_t expv);
      drive(a, b, 2'b00);
      @(negedge CLK);
      chk("lat_in_ready", 37'(in_ready), 37'(1));
      sb.push_back(expv);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK); chk("lat_cycle1", 37'(out_valid), 37'(0));
      @(negedge CLK); chk("lat_cycle2", 37'(out_valid), 37'(0));
      @(negedge CLK); chk("lat_cycle3", 37'(out_valid), 37'(1));
      @(posedge CLK); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge CLK);
         n++;
      end
      chk("drain", 37'(sb.size()), 37'(0));
      repeat (2) @(posedge CLK);
      #1;
   endtask

   // Output monitor: scoreboard compare, idle flags, hold-while-stalled
   always @(negedge CLK) begin
      if (RST) begin
         was_stall = 1'b0;
      end else begin
         if (!out_valid) begin
            chk("idle_flags", 37'(got[36:32]), 37'(0));
         end else if (out_ready) begin
            if (sb.size() == 0) chk("stale_result", 37'(out_valid), 37'(0));
            else chk("result", got, sb.pop_front());
         end
         if (out_valid && !out_ready) begin
            if (was_stall) chk("hold_stable", got, held);
            held      = got;
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      Sx = 1'b0; Sy = 1'b0; Ex = '0; Ey = '0; Mx = '0; My = '0; R_mode = 2'b00;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_out_valid", 37'(out_valid), 37'(0));
      chk("reset_in_ready", 37'(in_ready), 37'(1));
      chk("reset_outputs", got, 37'(0));
      @(posedge CLK); #1;
      RST = 1'b0;

      // 3.0 * 2.0 with latency
      lat_op(32'h40400000, 32'h40000000, {5'b00000, 32'h40C00000});

      // Specials, overflow per rounding mode, underflow, rounding
      send(32'h7F800000, 32'h00000000, 2'b00, 1'b1, {5'b10000, 32'h7FFFFFFF});
      send(32'h7FC00000, 32'h3F800000, 2'b00, 1'b1, {5'b10000, 32'h7FFFFFFF});
      send(32'h7F7FFFFF, 32'h40000000, 2'b00, 1'b1, {5'b01010, 32'h7F800000});
      send(32'h7F7FFFFF, 32'h40000000, 2'b01, 1'b1, {5'b01010, 32'h7F7FFFFF});
      send(32'hFF7FFFFF, 32'h40000000, 2'b10, 1'b1, {5'b01010, 32'hFF7FFFFF});
      send(32'hFF7FFFFF, 32'h40000000, 2'b11, 1'b1, {5'b01010, 32'hFF800000});
`ifdef FP_MUL_SUBNORM_EN
      send(32'h00800000, 32'h3F000000, 2'b00, 1'b1, {5'b00100, 32'h00400000});
      send(32'h00400000, 32'h40000000, 2'b00, 1'b1, {5'b00000, 32'h00800000});
`else
      send(32'h00800000, 32'h3F000000, 2'b00, 1'b1, {5'b00111, 32'h00000000});
      send(32'h00400000, 32'h40000000, 2'b00, 1'b1, {5'b00001, 32'h00000000});
`endif
      send(32'h7F800000, 32'hC0000000, 2'b00, 1'b1, {5'b00000, 32'hFF800000});
      send(32'h00000000, 32'h80000000, 2'b00, 1'b1, {5'b00001, 32'h80000000});
      send(32'h3F800001, 32'h3F800001, 2'b00, 1'b1, {5'b00010, 32'h3F800002});
      send(32'h3F800001, 32'h3F800001, 2'b10, 1'b1, {5'b00010, 32'h3F800003});
      send(32'hBF800001, 32'h3F800001, 2'b11, 1'b1, {5'b00010, 32'hBF800003});
      send(32'hBF800001, 32'h3F800001, 2'b01, 1'b1, {5'b00010, 32'hBF800002});
      drain();

      // Backpressure: six back-to-back ops against a stalled consumer
      out_ready = 1'b0;
      fork
         begin
            send(32'h3F800000, 32'h3F800000, 2'b00, 1'b1, {5'b00000, 32'h3F800000});
            send(32'h40400000, 32'h40000000, 2'b00, 1'b1, {5'b00000, 32'h40C00000});
            send(32'h40000000, 32'h40000000, 2'b00, 1'b1, {5'b00000, 32'h40800000});
            send(32'hBF800000, 32'h40400000, 2'b00, 1'b1, {5'b00000, 32'hC0400000});
            send(32'h3FC00000, 32'h3FC00000, 2'b00, 1'b1, {5'b00000, 32'h40100000});
            send(32'h40A00000, 32'h40E00000, 2'b00, 1'b1, {5'b00000, 32'h420C0000});
         end
         begin
            repeat (5) @(posedge CLK);
            @(negedge CLK);
            chk("bp_in_ready_low", 37'(in_ready), 37'(0));
            chk("bp_out_valid", 37'(out_valid), 37'(1));
            @(posedge CLK); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two operations in flight, one parked at the output
      out_ready = 1'b0;
      send(32'h40000000, 32'h40400000, 2'b00, 1'b0, '0);
      send(32'h40800000, 32'h40400000, 2'b00, 1'b0, '0);
      @(posedge CLK); #1;
      chk("pre_reset_valid", 37'(out_valid), 37'(1));
      RST = 1'b1;
      #1;
      chk("midrst_out_valid", 37'(out_valid), 37'(0));
      chk("midrst_in_ready", 37'(in_ready), 37'(1));
      chk("midrst_outputs", got, 37'(0));
      @(posedge CLK); #1;
      RST = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      lat_op(32'h40000000, 32'h40000000, {5'b00000, 32'h40800000});
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
